// File: rtl/encoder245.sv
// Sequential 24-to-5 request encoder: captures request lines into a pending
// register and issues their indices lowest-first over a valid/ready handshake.
module encoder245 (
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic [23:0] req,
    input  logic        ready,
    output logic [4:0]  code,
    output logic        valid,
    output logic [23:0] pend,
    output logic        any,
    output logic        ovf
);

    localparam int unsigned N = 24;
    localparam int unsigned W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   cap;
    logic [N-1:0]   grant;
    logic [N-1:0]   pend_nxt;
    logic [W-1:0]   sel;
    logic           load;
    logic           valid_nxt;

    // Capture gating, lowest-set-bit selection and next pending value.
    always_comb begin
        cap       = st ? req : '0;
        load      = (!valid || ready) && (pend != '0);
        sel       = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = W'(i);
            end
        end
        grant     = load ? (N'(1) << sel) : '0;
        pend_nxt  = (pend & ~grant) | cap;
        valid_nxt = load || (valid && !ready);
    end

    // Output handshake FSM; valid mirrors the BUSY state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            code  <= '0;
            valid <= 1'b0;
            pend  <= '0;
            any   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= BUSY;
                        code  <= sel;
                        valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (ready) begin
                        if (load) begin
                            code <= sel;
                        end else begin
                            state <= IDLE;
                            valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
            pend <= pend_nxt;
            // Registered copy of (pend != 0 || valid) so any tracks its sources exactly.
            any  <= (pend_nxt != '0) || valid_nxt;
            ovf  <= |(cap & pend & ~grant);
        end
    end

endmodule

// File: tb/tb_encoder245.sv
// Directed-vector bench for encoder245 with hand-computed expectations.
module tb_encoder245;

    logic        clk;
    logic        rst;
    logic        st;
    logic [23:0] req;
    logic        ready;
    logic [4:0]  code;
    logic        valid;
    logic [23:0] pend;
    logic        any;
    logic        ovf;

    int vectors;
    int miscompares;

    encoder245 dut (
        .clk   (clk),
        .rst   (rst),
        .st    (st),
        .req   (req),
        .ready (ready),
        .code  (code),
        .valid (valid),
        .pend  (pend),
        .any   (any),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [4:0] e_code, input logic e_valid,
                             input logic [23:0] e_pend, input logic e_any, input logic e_ovf);
        check({tag, ".code"},  32'(code),  32'(e_code));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".pend"},  32'(pend),  32'(e_pend));
        check({tag, ".any"},   32'(any),   32'(e_any));
        check({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
    endtask

    logic [4:0]  drain_codes [4];
    logic [23:0] drain_pend  [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        drain_codes = '{5'd0, 5'd5, 5'd10, 5'd23};
        drain_pend  = '{24'h800420, 24'h800400, 24'h800000, 24'h000000};
        rst   = 1'b1;
        st    = 1'b0;
        req   = '0;
        ready = 1'b0;

        // reset and single request
        tick();
        tick();
        check_out("reset", 5'd0, 1'b0, 24'h0, 1'b0, 1'b0);
        rst = 1'b0; st = 1'b1; req = 24'h000001; ready = 1'b1;
        tick();
        check_out("single.cap", 5'd0, 1'b0, 24'h000001, 1'b1, 1'b0);
        st = 1'b0; req = '0;
        tick();
        check_out("single.issue", 5'd0, 1'b1, 24'h0, 1'b1, 1'b0);
        tick();
        check_out("single.idle", 5'd0, 1'b0, 24'h0, 1'b0, 1'b0);

        // priority drain at full throughput
        st = 1'b1; req = 24'h800421;
        tick();
        check_out("drain.cap", 5'd0, 1'b0, 24'h800421, 1'b1, 1'b0);
        st = 1'b0; req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("drain.%0d", i), drain_codes[i], 1'b1, drain_pend[i], 1'b1, 1'b0);
        end
        tick();
        check_out("drain.idle", 5'd23, 1'b0, 24'h0, 1'b0, 1'b0);

        // backpressure holds code/valid/pend
        ready = 1'b0; st = 1'b1; req = 24'h800421;
        tick();
        check_out("bp.cap", 5'd23, 1'b0, 24'h800421, 1'b1, 1'b0);
        st = 1'b0; req = '0;
        tick();
        check_out("bp.first", 5'd0, 1'b1, 24'h800420, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("bp.hold%0d", i), 5'd0, 1'b1, 24'h800420, 1'b1, 1'b0);
        end
        ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check_out($sformatf("bp.drain%0d", i), drain_codes[i], 1'b1, drain_pend[i], 1'b1, 1'b0);
        end
        tick();
        check_out("bp.idle", 5'd23, 1'b0, 24'h0, 1'b0, 1'b0);

        // merge overflow on an already-pending bit
        ready = 1'b0; st = 1'b1; req = 24'h000081;
        tick();
        check_out("ovf.cap", 5'd23, 1'b0, 24'h000081, 1'b1, 1'b0);
        req = '0;
        tick();
        check_out("ovf.busy", 5'd0, 1'b1, 24'h000080, 1'b1, 1'b0);
        req = 24'h000080;
        tick();
        check_out("ovf.merge", 5'd0, 1'b1, 24'h000080, 1'b1, 1'b1);
        req = '0;
        tick();
        check_out("ovf.clear", 5'd0, 1'b1, 24'h000080, 1'b1, 1'b0);
        ready = 1'b1;
        tick();
        check_out("ovf.code7", 5'd7, 1'b1, 24'h0, 1'b1, 1'b0);
        tick();
        check_out("ovf.idle", 5'd7, 1'b0, 24'h0, 1'b0, 1'b0);

        // enable gating
        st = 1'b0; req = 24'hFFFFFF;
        tick();
        check_out("gate.0", 5'd7, 1'b0, 24'h0, 1'b0, 1'b0);
        tick();
        check_out("gate.1", 5'd7, 1'b0, 24'h0, 1'b0, 1'b0);

        // held request re-arms every cycle without overflow
        st = 1'b1; req = 24'h000008;
        tick();
        check_out("rearm.cap", 5'd7, 1'b0, 24'h000008, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("rearm.%0d", i), 5'd3, 1'b1, 24'h000008, 1'b1, 1'b0);
        end
        st = 1'b0; req = '0;
        tick();
        check_out("rearm.last", 5'd3, 1'b1, 24'h0, 1'b1, 1'b0);
        tick();
        check_out("rearm.idle", 5'd3, 1'b0, 24'h0, 1'b0, 1'b0);

        // reset mid-operation drops pending work
        ready = 1'b0; st = 1'b1; req = 24'h00F000;
        tick();
        check_out("mid.cap", 5'd3, 1'b0, 24'h00F000, 1'b1, 1'b0);
        tick();
        check_out("mid.busy", 5'd12, 1'b1, 24'h00F000, 1'b1, 1'b1);
        st = 1'b0; req = '0; rst = 1'b1;
        tick();
        check_out("mid.rst", 5'd0, 1'b0, 24'h0, 1'b0, 1'b0);
        rst = 1'b0; ready = 1'b1;
        tick();
        check_out("mid.after0", 5'd0, 1'b0, 24'h0, 1'b0, 1'b0);
        tick();
        check_out("mid.after1", 5'd0, 1'b0, 24'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
